// File: rtl/ins_queue_pkg.sv
// Shared constants and payload type for the fetch-to-decode instruction queue.
// The optional zero-latency bypass is enabled by defining INS_QUEUE_BYPASS_EN.
package ins_queue_pkg;

    localparam int unsigned INSQ_DEPTH = 4;
    localparam int unsigned INSQ_WIDTH = 32;

    // sll $0,$0,0
    localparam logic [INSQ_WIDTH-1:0] NOP_INS = 32'h0000_0000;

    // One buffered fetch result.
    typedef struct packed {
        logic [INSQ_WIDTH-1:0] pc;
        logic [INSQ_WIDTH-1:0] ins;
    } insq_entry_t;

    // Sequential successor of a PC, wrapping modulo 2^INSQ_WIDTH.
    function automatic logic [INSQ_WIDTH-1:0] insq_next_pc(input logic [INSQ_WIDTH-1:0] pc);
        return pc + INSQ_WIDTH'(4);
    endfunction

endpackage

// File: rtl/ins_queue_if.sv
// Fetch-side and decode-side handshake bundle of the instruction queue.
interface ins_queue_if
    import ins_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INSQ_DEPTH
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [INSQ_WIDTH-1:0] in_pc;
    logic [INSQ_WIDTH-1:0] in_ins;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [INSQ_WIDTH-1:0] out_pc;
    logic [INSQ_WIDTH-1:0] out_ins;
    logic [INSQ_WIDTH-1:0] out_nextpc;
    logic [CW-1:0]         count;

    // Pipeline side driving fetch results and decode acceptance.
    modport master (
        output in_valid, in_pc, in_ins, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_ins, out_nextpc, count
    );

    // Queue side.
    modport slave (
        input  in_valid, in_pc, in_ins, flush, out_ready,
        output in_ready, out_valid, out_pc, out_ins, out_nextpc, count
    );

endinterface

// File: rtl/ins_queue_ptr.sv
// Wrapping read/write pointer: increments on inc_i, wraps DEPTH-1 -> 0,
// synchronous clear on clr_i takes priority.
module ins_queue_ptr #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     inc_i,
    input  logic                     clr_i,
    output logic [$clog2(DEPTH)-1:0] ptr_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer value.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ins_queue.sv
// Instruction queue between fetch and decode: DEPTH-entry circular buffer of
// {pc, ins} pairs, valid/ready on both sides, flush on taken branch/jump.
// Decode sees NOP_INS whenever nothing is valid.
// INS_QUEUE_BYPASS_EN: an empty queue forwards in_* straight to out_*.
module ins_queue
    import ins_queue_pkg::*;
#(
    parameter int unsigned DEPTH = INSQ_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    ins_queue_if.slave q_if
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    insq_entry_t   mem_q [DEPTH];
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          full_c;
    logic          empty_c;
    logic          bypass_c;
    logic          push_c;
    logic          pop_c;
    insq_entry_t   head_c;
    logic          out_valid_c;
    logic [INSQ_WIDTH-1:0] out_pc_c;
    logic [INSQ_WIDTH-1:0] out_ins_c;

    assign full_c  = (count_q == CW'(DEPTH));
    assign empty_c = (count_q == '0);

`ifdef INS_QUEUE_BYPASS_EN
    assign bypass_c = empty_c & q_if.in_valid & ~q_if.flush;
`else
    assign bypass_c = 1'b0;
`endif

    // A bypassed pair consumed by decode in the same cycle is never stored.
    assign push_c = q_if.in_valid & ~full_c & ~q_if.flush & ~(bypass_c & q_if.out_ready);
    assign pop_c  = ~empty_c & q_if.out_ready & ~q_if.flush;

    ins_queue_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (push_c),
        .clr_i (q_if.flush),
        .ptr_o (wptr)
    );

    ins_queue_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (pop_c),
        .clr_i (q_if.flush),
        .ptr_o (rptr)
    );

    // Occupancy next state; flush wins over push/pop.
    always_comb begin
        count_d = count_q;
        if (q_if.flush) begin
            count_d = '0;
        end else if (push_c && !pop_c) begin
            count_d = count_q + CW'(1);
        end else if (pop_c && !push_c) begin
            count_d = count_q - CW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; not cleared by flush since empty output is masked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_c) begin
            mem_q[wptr] <= '{pc: q_if.in_pc, ins: q_if.in_ins};
        end
    end

    assign head_c = mem_q[rptr];

    // Head view for decode, with optional bypass and NOP masking.
    always_comb begin
        out_valid_c = ~empty_c;
        out_pc_c    = head_c.pc;
        out_ins_c   = head_c.ins;
        if (bypass_c) begin
            out_valid_c = 1'b1;
            out_pc_c    = q_if.in_pc;
            out_ins_c   = q_if.in_ins;
        end
        if (!out_valid_c) begin
            out_ins_c = NOP_INS;
        end
    end

    assign q_if.in_ready   = ~full_c;
    assign q_if.out_valid  = out_valid_c;
    assign q_if.out_pc     = out_pc_c;
    assign q_if.out_ins    = out_ins_c;
    assign q_if.out_nextpc = insq_next_pc(out_pc_c);
    assign q_if.count      = count_q;

endmodule

// File: tb/tb_ins_queue.sv
// Bench for ins_queue: reset checks, directed vector table, hand-written
// corner sequences and a random run against a queue-based reference model.
module tb_ins_queue;
    import ins_queue_pkg::*;

    localparam int unsigned DEPTH = INSQ_DEPTH;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    ins_queue_if #(.DEPTH(DEPTH)) q_if ();

    ins_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q_if  (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [31:0] pc;
        int          cnt;
        logic        vld;
        logic [31:0] epc;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [31:0] ins_of(input logic [31:0] pc);
        return pc ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [31:0] pc, input int cnt,
                                input logic vld, input logic [31:0] epc);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.fl = fl; v.pc = pc;
        v.cnt = cnt; v.vld = vld; v.epc = epc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic ordy, input logic fl);
        q_if.in_valid  = iv;
        q_if.in_pc     = pc;
        q_if.in_ins    = ins;
        q_if.out_ready = ordy;
        q_if.flush     = fl;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Applies one cycle of inputs, then checks post-edge state with inputs idle.
    task automatic apply_vec(input vec_t v, input int idx);
        string tag;
        drive(v.iv, v.pc, ins_of(v.pc), v.ordy, v.fl);
        @(posedge clk);
        #1;
        idle();
        #1;
        tag = $sformatf("vec%0d", idx);
        check({tag, ".count"}, 32'(q_if.count), 32'(v.cnt));
        check({tag, ".in_ready"}, 32'(q_if.in_ready), 32'(v.cnt != int'(DEPTH)));
        check({tag, ".out_valid"}, 32'(q_if.out_valid), 32'(v.vld));
        if (v.vld) begin
            check({tag, ".out_pc"}, q_if.out_pc, v.epc);
            check({tag, ".out_ins"}, q_if.out_ins, ins_of(v.epc));
            check({tag, ".out_nextpc"}, q_if.out_nextpc, v.epc + 32'd4);
        end else begin
            check({tag, ".out_ins_nop"}, q_if.out_ins, 32'h0);
        end
    endtask

    insq_entry_t mq [$];

    initial begin
        logic        iv, ordy, fl, byp, exp_valid, do_pop, do_push;
        logic [31:0] pc, ins, exp_pc, exp_ins;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();

        // Reset state before any clock edge.
        #2;
        check("rst.out_valid", 32'(q_if.out_valid), 32'h0);
        check("rst.out_ins", q_if.out_ins, 32'h0);
        check("rst.out_pc", q_if.out_pc, 32'h0);
        check("rst.out_nextpc", q_if.out_nextpc, 32'h4);
        check("rst.count", 32'(q_if.count), 32'h0);
        check("rst.in_ready", 32'(q_if.in_ready), 32'h1);

        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill, overflow, full push+pop, drain with wrap, push+pop at 1, flush.
        tbl[0]  = mk(1, 0, 0, 32'h00,  1, 1, 32'h00);
        tbl[1]  = mk(1, 0, 0, 32'h04,  2, 1, 32'h00);
        tbl[2]  = mk(1, 0, 0, 32'h08,  3, 1, 32'h00);
        tbl[3]  = mk(1, 0, 0, 32'h0C,  4, 1, 32'h00);
        tbl[4]  = mk(1, 0, 0, 32'h100, 4, 1, 32'h00);
        tbl[5]  = mk(1, 1, 0, 32'h200, 3, 1, 32'h04);
        tbl[6]  = mk(0, 1, 0, 32'h00,  2, 1, 32'h08);
        tbl[7]  = mk(0, 1, 0, 32'h00,  1, 1, 32'h0C);
        tbl[8]  = mk(0, 1, 0, 32'h00,  0, 0, 32'h00);
        tbl[9]  = mk(1, 0, 0, 32'h10,  1, 1, 32'h10);
        tbl[10] = mk(1, 0, 0, 32'h14,  2, 1, 32'h10);
        tbl[11] = mk(0, 1, 0, 32'h00,  1, 1, 32'h14);
        tbl[12] = mk(0, 1, 0, 32'h00,  0, 0, 32'h00);
        tbl[13] = mk(1, 0, 0, 32'h40,  1, 1, 32'h40);
        tbl[14] = mk(1, 1, 0, 32'h44,  1, 1, 32'h44);
        tbl[15] = mk(1, 0, 0, 32'h50,  2, 1, 32'h44);
        tbl[16] = mk(1, 0, 0, 32'h54,  3, 1, 32'h44);
        tbl[17] = mk(1, 1, 1, 32'h58,  0, 0, 32'h00);
        tbl[18] = mk(1, 0, 0, 32'h60,  1, 1, 32'h60);
        tbl[19] = mk(0, 1, 0, 32'h00,  0, 0, 32'h00);
        for (int i = 0; i < 20; i++) begin
            apply_vec(tbl[i], i);
        end

        // Empty queue, fetch presents 0x20 while decode is ready.
        drive(1'b1, 32'h20, ins_of(32'h20), 1'b1, 1'b0);
        #1;
`ifdef INS_QUEUE_BYPASS_EN
        check("byp.out_valid", 32'(q_if.out_valid), 32'h1);
        check("byp.out_pc", q_if.out_pc, 32'h20);
        check("byp.out_nextpc", q_if.out_nextpc, 32'h24);
        check("byp.out_ins", q_if.out_ins, ins_of(32'h20));
`else
        check("nobyp.out_valid", 32'(q_if.out_valid), 32'h0);
        check("nobyp.out_ins", q_if.out_ins, 32'h0);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
`ifdef INS_QUEUE_BYPASS_EN
        check("byp.count_after", 32'(q_if.count), 32'h0);
`else
        check("nobyp.count_after", 32'(q_if.count), 32'h1);
        check("nobyp.out_pc_after", q_if.out_pc, 32'h20);
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("drain.count", 32'(q_if.count), 32'h0);

        // Next-PC wraps modulo 2^32.
        drive(1'b1, 32'hFFFF_FFFC, ins_of(32'hFFFF_FFFC), 1'b0, 1'b0);
        @(posedge clk);
        #1;
        idle();
        #1;
        check("wrap.out_pc", q_if.out_pc, 32'hFFFF_FFFC);
        check("wrap.out_nextpc", q_if.out_nextpc, 32'h0);

        // Reset asserted mid-cycle clears the queue without a clock edge.
        drive(1'b1, 32'h70, ins_of(32'h70), 1'b0, 1'b0);
        @(posedge clk);
        #3;
        idle();
        rst_n = 1'b0;
        #1;
        check("midrst.count", 32'(q_if.count), 32'h0);
        check("midrst.out_valid", 32'(q_if.out_valid), 32'h0);
        check("midrst.in_ready", 32'(q_if.in_ready), 32'h1);
        check("midrst.out_ins", q_if.out_ins, 32'h0);
        check("midrst.out_pc", q_if.out_pc, 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random traffic against a queue model.
        mq.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = $urandom_range(0, 1) == 1;
            fl   = ($urandom_range(0, 19) == 0);
            pc   = $urandom;
            ins  = $urandom;
            drive(iv, pc, ins, ordy, fl);
            #2;
`ifdef INS_QUEUE_BYPASS_EN
            byp = (mq.size() == 0) && iv && !fl;
`else
            byp = 1'b0;
`endif
            exp_valid = (mq.size() != 0) || byp;
            exp_pc    = byp ? pc  : (mq.size() != 0 ? mq[0].pc  : 32'h0);
            exp_ins   = byp ? ins : (mq.size() != 0 ? mq[0].ins : 32'h0);
            check("rnd.count", 32'(q_if.count), 32'(mq.size()));
            check("rnd.in_ready", 32'(q_if.in_ready), 32'(mq.size() != int'(DEPTH)));
            check("rnd.out_valid", 32'(q_if.out_valid), 32'(exp_valid));
            check("rnd.out_ins", q_if.out_ins, exp_valid ? exp_ins : 32'h0);
            if (exp_valid) begin
                check("rnd.out_pc", q_if.out_pc, exp_pc);
                check("rnd.out_nextpc", q_if.out_nextpc, exp_pc + 32'd4);
            end
            @(posedge clk);
            if (fl) begin
                mq.delete();
            end else begin
                do_pop  = (mq.size() != 0) && ordy;
                do_push = iv && (mq.size() != int'(DEPTH)) && !(byp && ordy);
                if (do_pop) void'(mq.pop_front());
                if (do_push) mq.push_back('{pc: pc, ins: ins});
            end
            #1;
        end

        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
